// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes, datapath select encodings and the ALU operation class.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_AUIPC,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } statetype;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps the operation class requested by the FSM plus the
// instruction's funct fields onto an ALUControl code. Flags funct3 values
// this datapath does not implement.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    // Select the ALU function; unknown funct3 falls back to add.
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/
// writeback, drives datapath selects and enables, and decodes ImmSrc.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       Illegal
);

    statetype   state;
    statetype   state_next;
    aluop_t     aluop;
    logic [2:0] alu_ctrl;
    logic       alu_illegal;

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_ctrl),
        .illegal     (alu_illegal)
    );

    assign ALUControl = alu_ctrl;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; reset overrides everything to quiet
    // FETCH values so an abandoned instruction performs no further write.
    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        aluop      = ALUOP_ADD;
        Illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECR;
                    OP_IALU:      state_next = S_EXECI;
                    OP_JAL:       state_next = S_JAL;
                    OP_LUI:       state_next = S_LUI;
                    OP_AUIPC:     state_next = S_AUIPC;
                    OP_BRANCH: begin
                        // only beq/bne are implemented
                        if (funct3[2:1] == 2'b00) begin
                            state_next = S_BRANCH;
                        end else begin
                            state_next = S_FETCH;
                            Illegal    = 1'b1;
                        end
                    end
                    default: begin
                        state_next = S_FETCH;
                        Illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                aluop      = ALUOP_FUNCT;
                Illegal    = alu_illegal;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                Illegal    = alu_illegal;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = SRCA_ZERO;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                aluop      = ALUOP_SUB;
                ResultSrc  = RES_ALUOUT;
                // funct3[0] distinguishes bne from beq
                PCWrite    = Zero ^ funct3[0];
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase

        if (reset) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            Illegal   = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            aluop     = ALUOP_ADD;
        end
    end

    // Immediate format follows the opcode alone, in every state.
    always_comb begin
        case (op)
            OP_LW, OP_IALU:   ImmSrc = IMM_I;
            OP_SW:            ImmSrc = IMM_S;
            OP_BRANCH:        ImmSrc = IMM_B;
            OP_JAL:           ImmSrc = IMM_J;
            OP_LUI, OP_AUIPC: ImmSrc = IMM_U;
            default:          ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: steps instructions cycle by cycle
// and compares the full output bundle against hand-computed vectors.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       Illegal;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .Illegal    (Illegal)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed bundle, field order matches vec() below.
    logic [17:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal};

    function automatic logic [17:0] vec(input logic pcw, input logic adr,
                                        input logic mw, input logic irw,
                                        input logic rw, input logic [1:0] rs,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] alu, input logic [2:0] imm,
                                        input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
    endfunction

    // Common vectors: fetch with memory ready, fetch stalled / under reset,
    // decode, and ALU writeback.
    function automatic logic [17:0] v_fetch(input logic [2:0] imm);
        return vec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
    endfunction
    function automatic logic [17:0] v_quiet(input logic [2:0] imm);
        return vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
    endfunction
    function automatic logic [17:0] v_dec(input logic [2:0] imm);
        return vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
    endfunction
    function automatic logic [17:0] v_aluwb(input logic [2:0] imm);
        return vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0);
    endfunction

    // Sample mid-cycle (falling edge) and compare.
    task automatic chk(input string tag, input logic [17:0] e);
        @(negedge clk);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, e);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Directed instruction sequence.
    initial begin
        reset = 1'b1; MemReady = 1'b1; Zero = 1'b0;
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;

        chk("reset_c1", v_quiet(3'b000));
        chk("reset_c2", v_quiet(3'b000));

        // lw, MemReady high throughout: 5 cycles
        nxt(); reset = 1'b0;
        chk("lw_fetch", v_fetch(3'b000));
        nxt(); chk("lw_decode", v_dec(3'b000));
        nxt(); chk("lw_memadr", vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        nxt(); chk("lw_memread", vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        nxt(); chk("lw_memwb", vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));

        // sw with one stalled fetch cycle and three stalled write cycles
        nxt(); op = 7'b0100011; MemReady = 1'b0;
        chk("sw_fetch_stall", v_quiet(3'b001));
        nxt(); MemReady = 1'b1;
        chk("sw_fetch", v_fetch(3'b001));
        nxt(); chk("sw_decode", v_dec(3'b001));
        nxt(); chk("sw_memadr", vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
        nxt(); MemReady = 1'b0;
        chk("sw_memwrite_w1", vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
        nxt(); chk("sw_memwrite_w2", vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
        nxt(); chk("sw_memwrite_w3", vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
        nxt(); MemReady = 1'b1;
        chk("sw_memwrite_done", vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));

        // bne, Zero=0: taken
        nxt(); op = 7'b1100011; funct3 = 3'b001;
        chk("bne_fetch", v_fetch(3'b010));
        nxt(); chk("bne_decode", v_dec(3'b010));
        nxt(); chk("bne_taken", vec(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));

        // bne, Zero=1: not taken
        nxt(); Zero = 1'b1;
        chk("bne2_fetch", v_fetch(3'b010));
        nxt(); chk("bne2_decode", v_dec(3'b010));
        nxt(); chk("bne_not_taken", vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));

        // beq, Zero=1: taken
        nxt(); funct3 = 3'b000;
        chk("beq_fetch", v_fetch(3'b010));
        nxt(); chk("beq_decode", v_dec(3'b010));
        nxt(); chk("beq_taken", vec(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));

        // R-type sub
        nxt(); Zero = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        chk("sub_fetch", v_fetch(3'b000));
        nxt(); chk("sub_decode", v_dec(3'b000));
        nxt(); chk("sub_execr", vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        nxt(); chk("sub_aluwb", v_aluwb(3'b000));

        // addi with funct7b5 set must still add (op[5]=0)
        nxt(); op = 7'b0010011;
        chk("addi_fetch", v_fetch(3'b000));
        nxt(); chk("addi_decode", v_dec(3'b000));
        nxt(); chk("addi_execi", vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        nxt(); chk("addi_aluwb", v_aluwb(3'b000));

        // slti and R-type or
        nxt(); funct3 = 3'b010; funct7b5 = 1'b0;
        nxt(); nxt(); chk("slti_execi", vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 3'b000, 0));
        nxt(); nxt(); op = 7'b0110011; funct3 = 3'b110;
        nxt(); nxt(); chk("or_execr", vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 3'b000, 0));

        // R-type with unimplemented funct3: add, Illegal pulse in EXECR
        nxt(); nxt(); funct3 = 3'b001;
        nxt(); nxt(); chk("r_f3_illegal", vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 1));
        nxt(); chk("r_f3_aluwb", v_aluwb(3'b000));

        // lui
        nxt(); op = 7'b0110111; funct3 = 3'b000;
        chk("lui_fetch", v_fetch(3'b100));
        nxt(); chk("lui_decode", v_dec(3'b100));
        nxt(); chk("lui_exec", vec(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 3'b100, 0));
        nxt(); chk("lui_aluwb", v_aluwb(3'b100));

        // auipc
        nxt(); op = 7'b0010111;
        nxt(); nxt(); chk("auipc_exec", vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b100, 0));
        nxt(); chk("auipc_aluwb", v_aluwb(3'b100));

        // jal
        nxt(); op = 7'b1101111;
        chk("jal_fetch", v_fetch(3'b011));
        nxt(); chk("jal_decode", v_dec(3'b011));
        nxt(); chk("jal_exec", vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0));
        nxt(); chk("jal_aluwb", v_aluwb(3'b011));

        // undefined opcode: Illegal in DECODE, back to FETCH (2 cycles)
        nxt(); op = 7'b1111111;
        chk("undef_fetch", v_fetch(3'b000));
        nxt(); chk("undef_decode", vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1));
        nxt(); chk("undef_refetch", v_fetch(3'b000));

        // lw abandoned by reset while stalled in MEMREAD
        nxt(); op = 7'b0000011; funct3 = 3'b010;
        chk("rst_lw_decode", v_dec(3'b000));
        nxt(); chk("rst_lw_memadr", vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        nxt(); MemReady = 1'b0;
        chk("rst_lw_memread", vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        nxt(); reset = 1'b1; MemReady = 1'b1;
        chk("rst_in_memread", v_quiet(3'b000));
        nxt(); reset = 1'b0;
        chk("rst_after_fetch", v_fetch(3'b000));
        nxt(); chk("rst_after_decode", v_dec(3'b000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
